// File: rtl/mlsu_pkg.sv
// Shared types for the MLSU store deshuffle scheduler: default request meta
// layout and the in-order completion tracker entry.
package mlsu_pkg;

  localparam int unsigned ReqIdW      = 4;
  localparam int unsigned CmtCntW     = 3;
  localparam int unsigned SrcFieldW   = 4;  // room for up to 16 requesters
  localparam int unsigned MaxOutstDef = 4;

  typedef struct packed {
    logic [ReqIdW-1:0]  req_id;
    logic               vm;
    logic [CmtCntW-1:0] cmt_cnt;  // beats minus one
  } meta_glb_default_t;

  typedef struct packed {
    logic [ReqIdW-1:0]    req_id;
    logic [SrcFieldW-1:0] src;
    logic [CmtCntW-1:0]   cmt_cnt;
  } trk_entry_t;

endpackage

// File: rtl/mlsu_shf_sched_ptr.sv
// Circular queue pointer: index that wraps at Depth-1 and toggles a lap flag
// so equal indices can be told apart as full or empty.
module CircularQueuePtrTemplate #(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            incr_i,
  output logic [PtrW-1:0] value_o,
  output logic            flag_o
);

  logic [PtrW-1:0] value_reg;
  logic            flag_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_reg <= '0;
      flag_reg  <= 1'b0;
    end else if (incr_i) begin
      if (value_reg == PtrW'(Depth - 1)) begin
        value_reg <= '0;
        flag_reg  <= ~flag_reg;
      end else begin
        value_reg <= value_reg + 1'b1;
      end
    end
  end

  assign value_o = value_reg;
  assign flag_o  = flag_reg;

endmodule

// File: rtl/mlsu_shf_sched.sv
// Store deshuffle scheduler: round-robin meta issue from several requesters,
// in-order beat tracking of issued requests and a completion handshake.
module mlsu_shf_sched
  import mlsu_pkg::*;
#(
  parameter int unsigned NrReq    = 2,
  parameter int unsigned MaxOutst = mlsu_pkg::MaxOutstDef,
  parameter type         meta_glb_t = mlsu_pkg::meta_glb_default_t,
  localparam int unsigned SrcW    = (NrReq > 1) ? $clog2(NrReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NrReq-1:0]  req_valid_i,
  output logic [NrReq-1:0]  req_ready_o,
  input  meta_glb_t         req_i [NrReq],
  output logic              meta_valid_o,
  input  logic              meta_ready_i,
  output meta_glb_t         meta_o,
  input  logic              cmt_valid_i,
  output logic              cmt_ready_o,
  output logic              done_valid_o,
  input  logic              done_ready_i,
  output logic [ReqIdW-1:0] done_reqid_o,
  output logic [SrcW-1:0]   done_src_o,
  output logic              busy_o
);

  localparam int unsigned PtrW = (MaxOutst > 1) ? $clog2(MaxOutst) : 1;

  logic [SrcW-1:0]    rr_ptr_reg;
  logic               out_valid_reg;
  meta_glb_t          out_meta_reg;
  logic               done_valid_reg;
  logic [ReqIdW-1:0]  done_reqid_reg;
  logic [SrcW-1:0]    done_src_reg;
  logic [CmtCntW-1:0] beat_cnt_reg;
  trk_entry_t         trk_mem [MaxOutst];

  logic               gnt_valid;
  logic [SrcW-1:0]    gnt_idx;
  logic               accept_ok;
  logic               accept;
  logic               issue;
  logic [PtrW-1:0]    enq_ptr, deq_ptr;
  logic               enq_flag, deq_flag;
  logic               trk_empty, trk_full;
  trk_entry_t         head;
  trk_entry_t         push_entry;
  logic               last_beat;
  logic               cmt_fire;
  logic               pop;

  // Round-robin: search starts at rr_ptr_reg, which holds last grant + 1.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NrReq; k++) begin
      if (!gnt_valid && req_valid_i[(int'(rr_ptr_reg) + k) % NrReq]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SrcW'((int'(rr_ptr_reg) + k) % NrReq);
      end
    end
  end

  assign issue     = out_valid_reg && meta_ready_i;
  // A pop in the same cycle does not free a slot for acceptance.
  assign accept_ok = (!out_valid_reg || issue) && !trk_full;
  assign accept    = accept_ok && gnt_valid;

  for (genvar gi = 0; gi < NrReq; gi++) begin : g_ready
    assign req_ready_o[gi] = accept && (gnt_idx == SrcW'(gi));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_reg    <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr_reg    <= (gnt_idx == SrcW'(NrReq - 1)) ? '0 : gnt_idx + 1'b1;
        out_valid_reg <= 1'b1;
      end else if (issue) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      out_meta_reg <= req_i[gnt_idx];
    end
  end

  assign meta_valid_o = out_valid_reg;
  assign meta_o       = out_meta_reg;

  CircularQueuePtrTemplate #(.Depth(MaxOutst)) u_enq_ptr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .incr_i  (accept),
    .value_o (enq_ptr),
    .flag_o  (enq_flag)
  );

  CircularQueuePtrTemplate #(.Depth(MaxOutst)) u_deq_ptr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .incr_i  (pop),
    .value_o (deq_ptr),
    .flag_o  (deq_flag)
  );

  assign trk_empty = (enq_ptr == deq_ptr) && (enq_flag == deq_flag);
  assign trk_full  = (enq_ptr == deq_ptr) && (enq_flag != deq_flag);

  always_comb begin
    push_entry         = '0;
    push_entry.req_id  = ReqIdW'(req_i[gnt_idx].req_id);
    push_entry.src     = SrcFieldW'(gnt_idx);
    push_entry.cmt_cnt = CmtCntW'(req_i[gnt_idx].cmt_cnt);
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      trk_mem[enq_ptr] <= push_entry;
    end
  end

  assign head      = trk_mem[deq_ptr];
  assign last_beat = (beat_cnt_reg == head.cmt_cnt);
  // The final beat must not retire into a done register that cannot drain.
  assign cmt_ready_o = !trk_empty && !(last_beat && done_valid_reg && !done_ready_i);
  assign cmt_fire    = cmt_valid_i && cmt_ready_o;
  assign pop         = cmt_fire && last_beat;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_reg   <= '0;
      done_valid_reg <= 1'b0;
    end else begin
      if (pop) begin
        beat_cnt_reg <= '0;
      end else if (cmt_fire) begin
        beat_cnt_reg <= beat_cnt_reg + 1'b1;
      end
      if (pop) begin
        done_valid_reg <= 1'b1;
      end else if (done_ready_i) begin
        done_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (pop) begin
      done_reqid_reg <= head.req_id;
      done_src_reg   <= SrcW'(head.src);
    end
  end

  assign done_valid_o = done_valid_reg;
  assign done_reqid_o = done_reqid_reg;
  assign done_src_o   = done_src_reg;
  assign busy_o       = out_valid_reg || !trk_empty || done_valid_reg;

endmodule

// File: tb/tb_mlsu_shf_sched.sv
// Directed bench for mlsu_shf_sched: arbitration order, beat counting,
// tracker back-pressure, done stall, meta stall and mid-flight reset.
module tb_mlsu_shf_sched;
  import mlsu_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [1:0]        req_valid_i;
  logic [1:0]        req_ready_o;
  meta_glb_default_t req_i [2];
  logic              meta_valid_o;
  logic              meta_ready_i;
  meta_glb_default_t meta_o;
  logic              cmt_valid_i;
  logic              cmt_ready_o;
  logic              done_valid_o;
  logic              done_ready_i;
  logic [ReqIdW-1:0] done_reqid_o;
  logic [0:0]        done_src_o;
  logic              busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  mlsu_shf_sched dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_i        (req_i),
    .meta_valid_o (meta_valid_o),
    .meta_ready_i (meta_ready_i),
    .meta_o       (meta_o),
    .cmt_valid_i  (cmt_valid_i),
    .cmt_ready_o  (cmt_ready_o),
    .done_valid_o (done_valid_o),
    .done_ready_i (done_ready_i),
    .done_reqid_o (done_reqid_o),
    .done_src_o   (done_src_o),
    .busy_o       (busy_o)
  );

  function automatic meta_glb_default_t mk(input int id, input bit vm, input int cnt);
    meta_glb_default_t m;
    m.req_id  = ReqIdW'(id);
    m.vm      = vm;
    m.cmt_cnt = CmtCntW'(cnt);
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) begin
      $display("[TB] ok   %s = %0h", tag, obs);
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni       = 1'b0;
    req_valid_i  = '0;
    req_i[0]     = mk(0, 0, 0);
    req_i[1]     = mk(0, 0, 0);
    meta_ready_i = 1'b1;
    cmt_valid_i  = 1'b0;
    done_ready_i = 1'b1;
    tick();
    tick();
    #1;
    check("rst_meta_valid", 32'(meta_valid_o), 0);
    check("rst_done_valid", 32'(done_valid_o), 0);
    check("rst_busy",       32'(busy_o), 0);
    check("rst_cmt_ready",  32'(cmt_ready_o), 0);
    check("rst_req_ready",  32'(req_ready_o), 0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Round-robin alternation with single-beat requests
    req_i[0]    = mk(1, 0, 0);
    req_i[1]    = mk(2, 0, 0);
    req_valid_i = 2'b11;
    cmt_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr_ready_%0d", i), 32'(req_ready_o), (i % 2) ? 32'h2 : 32'h1);
      if (i >= 2) begin
        check($sformatf("rr_done_src_%0d", i), 32'(done_src_o), 32'(i % 2));
        check($sformatf("rr_done_id_%0d", i), 32'(done_reqid_o), (i % 2) ? 32'd2 : 32'd1);
      end
      tick();
    end
    req_valid_i = '0;
    repeat (6) tick();
    #1;
    check("rr_idle_busy", 32'(busy_o), 0);
    cmt_valid_i = 1'b0;
    tick();

    // Four-beat request: done only after the fourth commit
    req_i[0]    = mk(5, 0, 3);
    req_valid_i = 2'b01;
    tick();
    req_valid_i = '0;
    #1;
    check("mb_meta_id", 32'(meta_o.req_id), 5);
    tick();
    cmt_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("mb_cmt_ready_%0d", k), 32'(cmt_ready_o), 1);
      check($sformatf("mb_no_done_%0d", k), 32'(done_valid_o), 0);
      tick();
    end
    #1;
    check("mb_done_valid", 32'(done_valid_o), 1);
    check("mb_done_id",    32'(done_reqid_o), 5);
    check("mb_cmt_empty",  32'(cmt_ready_o), 0);
    cmt_valid_i = 1'b0;
    tick();

    // Tracker full: fifth request blocked until a pop has happened
    req_valid_i = 2'b01;
    for (int k = 0; k < 4; k++) begin
      req_i[0] = mk(8 + k, 0, 0);
      #1;
      check($sformatf("full_fill_%0d", k), 32'(req_ready_o), 1);
      tick();
    end
    req_i[0] = mk(12, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("full_block_%0d", k), 32'(req_ready_o), 0);
      tick();
    end
    cmt_valid_i = 1'b1;
    #1;
    check("full_pop_cycle_ready", 32'(req_ready_o), 0);
    check("full_pop_cmt_ready",   32'(cmt_ready_o), 1);
    tick();
    cmt_valid_i = 1'b0;
    #1;
    check("full_after_pop", 32'(req_ready_o), 1);
    tick();
    req_valid_i = '0;
    cmt_valid_i = 1'b1;
    repeat (8) tick();
    cmt_valid_i = 1'b0;
    #1;
    check("full_drained_busy", 32'(busy_o), 0);
    tick();

    // Done back-pressure holds the last beat of the next head
    done_ready_i = 1'b0;
    req_valid_i  = 2'b10;
    req_i[1]     = mk(3, 0, 0);
    tick();
    req_i[1]     = mk(4, 0, 0);
    tick();
    req_valid_i  = '0;
    cmt_valid_i  = 1'b1;
    #1;
    check("dn_first_ready", 32'(cmt_ready_o), 1);
    tick();
    for (int k = 0; k < 2; k++) begin
      #1;
      check($sformatf("dn_hold_ready_%0d", k), 32'(cmt_ready_o), 0);
      check($sformatf("dn_hold_id_%0d", k), 32'(done_reqid_o), 3);
      tick();
    end
    done_ready_i = 1'b1;
    #1;
    check("dn_release_ready", 32'(cmt_ready_o), 1);
    tick();
    #1;
    check("dn_second_valid", 32'(done_valid_o), 1);
    check("dn_second_id",    32'(done_reqid_o), 4);
    cmt_valid_i = 1'b0;
    tick();
    #1;
    check("dn_idle_busy", 32'(busy_o), 0);
    tick();

    // Meta stall: output held and a second request is refused
    meta_ready_i = 1'b0;
    req_i[0]     = mk(6, 1, 1);
    req_valid_i  = 2'b01;
    tick();
    req_i[1]     = mk(7, 0, 0);
    req_valid_i  = 2'b10;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("st_valid_%0d", k), 32'(meta_valid_o), 1);
      check($sformatf("st_meta_%0d", k), 32'(meta_o), 32'(mk(6, 1, 1)));
      check($sformatf("st_block_%0d", k), 32'(req_ready_o), 0);
      tick();
    end
    meta_ready_i = 1'b1;
    #1;
    check("st_drain_accept", 32'(req_ready_o), 2);
    tick();
    req_valid_i = '0;
    #1;
    check("st_next_meta", 32'(meta_o.req_id), 7);
    check("st_busy", 32'(busy_o), 1);

    // Reset with two requests tracked: nothing survives
    rst_ni = 1'b0;
    #1;
    check("rs_meta_valid", 32'(meta_valid_o), 0);
    check("rs_done_valid", 32'(done_valid_o), 0);
    check("rs_busy",       32'(busy_o), 0);
    check("rs_cmt_ready",  32'(cmt_ready_o), 0);
    tick();
    tick();
    rst_ni      = 1'b1;
    cmt_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      check($sformatf("rs_no_done_%0d", k), 32'(done_valid_o), 0);
      check($sformatf("rs_no_cmt_%0d", k), 32'(cmt_ready_o), 0);
    end
    check("rs_final_busy", 32'(busy_o), 0);
    cmt_valid_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
